// File: rtl/umi_fifo_sim.sv
// umi_fifo_sim: show-ahead FIFO for UMI packets {data, srcaddr, dstaddr, cmd}.
// Decouples an upstream packet source from a downstream UMI port and reports
// its occupancy.
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. A producer holds its payload stable while valid && !ready. Here
// in_ready and out_valid come only from registered pointers, so neither
// depends combinationally on the other side's handshake.
//
// Optional build macro UMI_FIFO_STATS_EN adds the outputs pkts_in, pkts_out
// (cumulative push/pop counts) and max_count (occupancy high-water mark).
module umi_fifo_sim #(
  parameter int DW    = 256,
  parameter int AW    = 64,
  parameter int CW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [DW-1:0]            in_data,
  input  logic [AW-1:0]            in_srcaddr,
  input  logic [AW-1:0]            in_dstaddr,
  input  logic [CW-1:0]            in_cmd,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [DW-1:0]            out_data,
  output logic [AW-1:0]            out_srcaddr,
  output logic [AW-1:0]            out_dstaddr,
  output logic [CW-1:0]            out_cmd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
`ifdef UMI_FIFO_STATS_EN
  ,
  output logic [31:0]              pkts_in,
  output logic [31:0]              pkts_out,
  output logic [$clog2(DEPTH):0]   max_count
`endif
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  localparam int PW = $clog2(DEPTH) + 1;
  localparam int IW = PW - 1;

  // Payload storage is deliberately left unreset; empty outputs are masked.
  logic [DW-1:0] data_mem [DEPTH];
  logic [AW-1:0] src_mem  [DEPTH];
  logic [AW-1:0] dst_mem  [DEPTH];
  logic [CW-1:0] cmd_mem  [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [IW-1:0] wr_idx, rd_idx;
  logic          full, empty, push, pop;

  // Flags, handshakes, next pointers and the show-ahead head outputs.
  always_comb begin
    wr_idx      = wr_ptr_q[IW-1:0];
    rd_idx      = rd_ptr_q[IW-1:0];
    full        = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) && (wr_idx == rd_idx);
    empty       = (wr_ptr_q == rd_ptr_q);
    in_ready    = !full;
    out_valid   = !empty;
    push        = in_valid && in_ready;
    pop         = out_valid && out_ready;
    wr_ptr_d    = wr_ptr_q + {{IW{1'b0}}, push};
    rd_ptr_d    = rd_ptr_q + {{IW{1'b0}}, pop};
    count       = wr_ptr_q - rd_ptr_q;
    out_data    = '0;
    out_srcaddr = '0;
    out_dstaddr = '0;
    out_cmd     = '0;
    if (!empty) begin
      out_data    = data_mem[rd_idx];
      out_srcaddr = src_mem[rd_idx];
      out_dstaddr = dst_mem[rd_idx];
      out_cmd     = cmd_mem[rd_idx];
    end
  end

  // Pointer registers; reset empties the FIFO immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Payload write on an accepted push.
  always_ff @(posedge clk) begin
    if (push) begin
      data_mem[wr_idx] <= in_data;
      src_mem[wr_idx]  <= in_srcaddr;
      dst_mem[wr_idx]  <= in_dstaddr;
      cmd_mem[wr_idx]  <= in_cmd;
    end
  end

`ifdef UMI_FIFO_STATS_EN
  logic [31:0]   pkts_in_q, pkts_in_d;
  logic [31:0]   pkts_out_q, pkts_out_d;
  logic [PW-1:0] max_count_q, max_count_d;
  logic [PW-1:0] count_d;

  // Traffic counters wrap naturally; the high-water mark tracks next occupancy.
  always_comb begin
    pkts_in_d   = pkts_in_q + {31'd0, push};
    pkts_out_d  = pkts_out_q + {31'd0, pop};
    count_d     = wr_ptr_d - rd_ptr_d;
    max_count_d = (count_d > max_count_q) ? count_d : max_count_q;
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkts_in_q   <= '0;
      pkts_out_q  <= '0;
      max_count_q <= '0;
    end else begin
      pkts_in_q   <= pkts_in_d;
      pkts_out_q  <= pkts_out_d;
      max_count_q <= max_count_d;
    end
  end

  assign pkts_in   = pkts_in_q;
  assign pkts_out  = pkts_out_q;
  assign max_count = max_count_q;
`endif

endmodule

// File: tb/tb_umi_fifo_sim.sv
// tb_umi_fifo_sim: directed bench for umi_fifo_sim (DEPTH=4). Inputs are
// driven and outputs sampled at the falling clk edge; the DUT acts on the
// rising edge. Statistics checks are compiled only with UMI_FIFO_STATS_EN.
module tb_umi_fifo_sim;
  localparam int DW    = 256;
  localparam int AW    = 64;
  localparam int CW    = 32;
  localparam int DEPTH = 4;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset;
  logic [DW-1:0]   in_data;
  logic [AW-1:0]   in_srcaddr, in_dstaddr;
  logic [CW-1:0]   in_cmd;
  logic            in_valid, in_ready;
  logic [DW-1:0]   out_data;
  logic [AW-1:0]   out_srcaddr, out_dstaddr;
  logic [CW-1:0]   out_cmd;
  logic            out_valid, out_ready;
  logic [CNTW-1:0] count;
`ifdef UMI_FIFO_STATS_EN
  logic [31:0]     pkts_in, pkts_out;
  logic [CNTW-1:0] max_count;
`endif

  int checks   = 0;
  int failures = 0;
  logic [15:0] exp_q[$];
  logic        p;

  umi_fifo_sim #(.DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_srcaddr(in_srcaddr), .in_dstaddr(in_dstaddr),
    .in_cmd(in_cmd), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_srcaddr(out_srcaddr), .out_dstaddr(out_dstaddr),
    .out_cmd(out_cmd), .out_valid(out_valid), .out_ready(out_ready),
    .count(count)
`ifdef UMI_FIFO_STATS_EN
    , .pkts_in(pkts_in), .pkts_out(pkts_out), .max_count(max_count)
`endif
  );

  // Clock and reset.
  always #5 clk = ~clk;

  // Packet field generators keyed by a 16-bit sequence number.
  function automatic logic [DW-1:0] mk_data(input logic [15:0] s);
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = {s, 16'(i) ^ 16'hA5A5};
    return d;
  endfunction
  function automatic logic [CW-1:0] mk_cmd(input logic [15:0] s);
    return {16'hC0DE, s};
  endfunction
  function automatic logic [AW-1:0] mk_src(input logic [15:0] s);
    return {48'h0000_5AC0_0000, s};
  endfunction
  function automatic logic [AW-1:0] mk_dst(input logic [15:0] s);
    return {48'h0000_D570_0000, s};
  endfunction

  // Driver tasks.
  task automatic drive_pkt(input logic [15:0] s);
    in_valid   = 1'b1;
    in_data    = mk_data(s);
    in_srcaddr = mk_src(s);
    in_dstaddr = mk_dst(s);
    in_cmd     = mk_cmd(s);
  endtask

  // One clock: records accepted push/pop in the scoreboard, returns at negedge.
  task automatic tick(output logic pushed);
    logic psh, pp;
    psh = in_valid && in_ready;
    pp  = out_valid && out_ready;
    @(posedge clk);
    if (pp && exp_q.size() > 0) void'(exp_q.pop_front());
    if (psh) exp_q.push_back(in_cmd[15:0]);
    @(negedge clk);
    pushed = psh;
  endtask

  task automatic apply_reset();
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_data   = '0;
    in_srcaddr = '0;
    in_dstaddr = '0;
    in_cmd    = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    apply_reset();
    tick(p);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++; if (out_cmd !== 32'h0) begin failures++; $display("FAIL reset_out_cmd got=%h want=0", out_cmd); end
    checks++; if (out_data !== '0) begin failures++; $display("FAIL reset_out_data got=%h want=0", out_data); end
  endtask

  task automatic test_single();
    in_valid   = 1'b1;
    in_cmd     = 32'h0000_0011;
    in_dstaddr = 64'h1000;
    in_srcaddr = 64'h2000;
    in_data    = mk_data(16'h0011);
    out_ready  = 1'b1;
    tick(p);
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b want=1", out_valid); end
    checks++; if (out_cmd !== 32'h0000_0011) begin failures++; $display("FAIL single_cmd got=%h want=00000011", out_cmd); end
    checks++; if (out_dstaddr !== 64'h1000) begin failures++; $display("FAIL single_dst got=%h want=1000", out_dstaddr); end
    checks++; if (out_srcaddr !== 64'h2000) begin failures++; $display("FAIL single_src got=%h want=2000", out_srcaddr); end
    checks++; if (out_data !== mk_data(16'h0011)) begin failures++; $display("FAIL single_data got=%h", out_data); end
    checks++; if (count !== 3'd1) begin failures++; $display("FAIL single_count1 got=%0d want=1", count); end
    tick(p);
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL single_count0 got=%0d/%b want=0/0", count, out_valid); end
`ifdef UMI_FIFO_STATS_EN
    checks++; if (pkts_in !== 32'd1 || pkts_out !== 32'd1) begin failures++; $display("FAIL single_stats got=%0d/%0d want=1/1", pkts_in, pkts_out); end
`endif
    exp_q.delete();
  endtask

  task automatic test_fill_drain();
    logic [15:0] want;
    out_ready = 1'b0;
    for (int s = 0; s < 4; s++) begin drive_pkt(16'(s)); tick(p); end
    drive_pkt(16'd4);
    checks++; if (count !== 3'd4) begin failures++; $display("FAIL fill_count got=%0d want=4", count); end
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
    tick(p); tick(p);
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin failures++; $display("FAIL fill_hold got=%0d/%b want=4/0", count, in_ready); end
    checks++; if (out_cmd !== mk_cmd(16'd0)) begin failures++; $display("FAIL fill_head_stable got=%h want=%h", out_cmd, mk_cmd(16'd0)); end
`ifdef UMI_FIFO_STATS_EN
    checks++; if (max_count !== 3'd4) begin failures++; $display("FAIL stats_max got=%0d want=4", max_count); end
`endif
    out_ready = 1'b1;
    want = 16'd0;
    for (int i = 0; i < 30 && (want < 16'd5); i++) begin
      if (out_valid) begin
        checks++;
        if (out_cmd !== mk_cmd(want) || out_data !== mk_data(want) || out_srcaddr !== mk_src(want) || out_dstaddr !== mk_dst(want)) begin
          failures++; $display("FAIL fill_order got_cmd=%h want_cmd=%h", out_cmd, mk_cmd(want));
        end
        want++;
      end
      tick(p);
      if (p) in_valid = 1'b0;
    end
    checks++; if (want !== 16'd5 || count !== 3'd0 || exp_q.size() != 0) begin failures++; $display("FAIL fill_drain_done got=%0d pkts count=%0d want=5 pkts count=0", want, count); end
  endtask

  task automatic test_full_pop();
    out_ready = 1'b0;
    for (int s = 10; s < 14; s++) begin drive_pkt(16'(s)); tick(p); end
    drive_pkt(16'd14);
    out_ready = 1'b1;
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin failures++; $display("FAIL fullpop_pre got=%0d/%b want=4/0", count, in_ready); end
    tick(p);
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL fullpop_count got=%0d want=3", count); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL fullpop_in_ready got=%b want=1", in_ready); end
    checks++; if (out_cmd !== mk_cmd(16'd11)) begin failures++; $display("FAIL fullpop_head got=%h want=%h", out_cmd, mk_cmd(16'd11)); end
    for (int i = 0; i < 30 && (exp_q.size() > 0 || in_valid); i++) begin
      if (out_valid) begin
        checks++;
        if (exp_q.size() == 0 || out_cmd !== mk_cmd(exp_q[0])) begin
          failures++; $display("FAIL fullpop_order got=%h", out_cmd);
        end
      end
      tick(p);
      if (p) in_valid = 1'b0;
    end
    checks++; if (count !== 3'd0 || exp_q.size() != 0) begin failures++; $display("FAIL fullpop_drain got=%0d want=0", count); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] s;
    out_ready = 1'b0;
    drive_pkt(16'd100); tick(p);
    drive_pkt(16'd101); tick(p);
    checks++; if (count !== 3'd2) begin failures++; $display("FAIL b2b_pre got=%0d want=2", count); end
    out_ready = 1'b1;
    s = 16'd102;
    drive_pkt(s);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (count !== 3'd2 || out_cmd !== mk_cmd(16'(100 + i))) begin
        failures++; $display("FAIL b2b_cycle%0d got=%0d/%h want=2/%h", i, count, out_cmd, mk_cmd(16'(100 + i)));
      end
      tick(p);
      if (p) begin s++; drive_pkt(s); end
    end
    in_valid = 1'b0;
    checks++; if (out_cmd !== mk_cmd(16'd120) || count !== 3'd2) begin failures++; $display("FAIL b2b_tail got=%h/%0d want=%h/2", out_cmd, count, mk_cmd(16'd120)); end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) tick(p);
    checks++; if (count !== 3'd0 || exp_q.size() != 0) begin failures++; $display("FAIL b2b_drain got=%0d want=0", count); end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    for (int s = 200; s < 203; s++) begin drive_pkt(16'(s)); tick(p); end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3) begin failures++; $display("FAIL areset_pre got=%0d want=3", count); end
    #2 reset = 1'b1;
    #1;
    checks++; if (count !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL areset_now got=%0d/%b want=0/0", count, out_valid); end
    checks++; if (out_cmd !== 32'h0 || in_ready !== 1'b1) begin failures++; $display("FAIL areset_outs got=%h/%b want=0/1", out_cmd, in_ready); end
`ifdef UMI_FIFO_STATS_EN
    checks++; if (pkts_in !== 32'd0 || pkts_out !== 32'd0 || max_count !== 3'd0) begin failures++; $display("FAIL areset_stats got=%0d/%0d/%0d want=0/0/0", pkts_in, pkts_out, max_count); end
`endif
    @(negedge clk);
    reset = 1'b0;
    exp_q.delete();
    drive_pkt(16'd210);
    tick(p);
    in_valid = 1'b0;
    checks++; if (count !== 3'd1 || out_cmd !== mk_cmd(16'd210)) begin failures++; $display("FAIL areset_after got=%0d/%h want=1/%h", count, out_cmd, mk_cmd(16'd210)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_drain();
    test_full_pop();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
